// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with programmable repeat count and inter-repetition gap.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after every repetition.
//
// state  | meaning
// IDLE   | waiting for start, x_out parked at IDLE_BIT
// SEND   | shifting pattern (and parity) bits out, one per clock
// GAP    | idle cycles between repetitions, still busy
// DONE   | one-cycle done pulse, then back to IDLE
module seq_pattern_gen #(
  parameter int unsigned PAT_W    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GAP_W    = 4,
  parameter logic        IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned REP_LEN = PAT_W + 1;
`else
  localparam int unsigned REP_LEN = PAT_W;
`endif
  localparam int unsigned       BIT_W    = $clog2(PAT_W + 2);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(REP_LEN);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0]  REP_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
`ifdef SEQ_GEN_PARITY_EN
  localparam logic [BIT_W-1:0]  PAR_IDX  = BIT_W'(PAT_W);
`endif

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [PAT_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               x_out_q, x_out_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SEQ_GEN_PARITY_EN
  logic               parity_q, parity_d;
`endif
  logic               send_bit;

  // bit_cnt_q counts bits already launched in this repetition
  always_comb begin
    send_bit = shift_q[PAT_W-1];
`ifdef SEQ_GEN_PARITY_EN
    if (bit_cnt_q == PAR_IDX) send_bit = parity_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    rep_cnt_d = rep_cnt_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    x_out_d   = x_out_q;
    x_valid_d = x_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        x_out_d   = IDLE_BIT;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        if (start && !abort) begin
          state_d   = S_SEND;
          shadow_d  = pattern;
          shift_d   = {pattern[PAT_W-2:0], 1'b0};
          rep_cnt_d = (repeat_cnt == '0) ? REP_ONE : repeat_cnt;
          gap_d     = gap;
          bit_cnt_d = BIT_ONE;
          x_out_d   = pattern[PAT_W-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
          parity_d  = ^pattern;
`endif
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d   = S_IDLE;
          x_out_d   = IDLE_BIT;
          x_valid_d = 1'b0;
          busy_d    = 1'b0;
        end else if (bit_cnt_q != LAST_BIT) begin
          x_out_d   = send_bit;
          shift_d   = {shift_q[PAT_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end else begin
          rep_cnt_d = rep_cnt_q - REP_ONE;
          if (rep_cnt_q == REP_ONE) begin
            state_d   = S_DONE;
            x_out_d   = IDLE_BIT;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
            x_out_d   = IDLE_BIT;
            x_valid_d = 1'b0;
          end else begin
            shift_d   = {shadow_q[PAT_W-2:0], 1'b0};
            bit_cnt_d = BIT_ONE;
            x_out_d   = shadow_q[PAT_W-1];
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
        end else if (gap_cnt_q == GAP_ONE) begin
          state_d   = S_SEND;
          shift_d   = {shadow_q[PAT_W-2:0], 1'b0};
          bit_cnt_d = BIT_ONE;
          x_out_d   = shadow_q[PAT_W-1];
          x_valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        x_out_d   = IDLE_BIT;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      shadow_q  <= '0;
      rep_cnt_q <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      x_out_q   <= IDLE_BIT;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      rep_cnt_q <= rep_cnt_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: queue-based stream model checked every cycle, plus literal bit/latency checks.
// Honours SEQ_GEN_PARITY_EN the same way as the design.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
`ifdef SEQ_GEN_PARITY_EN
  localparam int L = 5;
`else
  localparam int L = 4;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             x_out, x_valid, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .repeat_cnt(repeat_cnt),
    .gap(gap), .abort(abort), .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
  );

  // {x_out, x_valid, busy, done} expected for one cycle
  typedef struct packed {logic x_out; logic x_valid; logic busy; logic done;} obs_t;
  localparam obs_t IDLE_OBS = 4'b1000;

  obs_t exp_q[$];
  obs_t cur = IDLE_OBS;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic void build(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] r,
                                input logic [GAP_W-1:0] g);
    int reps = (r == 0) ? 1 : int'(r);
    for (int k = 0; k < reps; k++) begin
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({pat[i], 1'b1, 1'b1, 1'b0});
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back({^pat, 1'b1, 1'b1, 1'b0});
`endif
      if (k < reps - 1)
        for (int j = 0; j < int'(g); j++) exp_q.push_back(4'b1010);
    end
    exp_q.push_back(4'b1001);
  endfunction

  // model: whole transfer is expanded into a queue when start is accepted
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        cur = IDLE_OBS;
      end else if (cur.busy || cur.done) begin
        if (abort && !cur.done) begin
          exp_q.delete();
          cur = IDLE_OBS;
        end else if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = IDLE_OBS;
      end else if (start && !abort) begin
        build(pattern, repeat_cnt, gap);
        cur = exp_q.pop_front();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) chk("stream", {x_out, x_valid, busy, done}, cur);
    end
  end

  task automatic run_xfer(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] r,
                          input logic [GAP_W-1:0] g, input int poke,
                          output logic [63:0] bits, output int nb, output int dc);
    bits = '0; nb = 0; dc = -1;
    @(negedge clk);
    pattern = pat; repeat_cnt = r; gap = g; start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0; pattern = pat;
      if (k == poke) begin
        start = 1'b1; pattern = ~pat; repeat_cnt = 8'd5;
      end
      if (x_valid) begin
        bits = {bits[62:0], x_out};
        nb++;
      end
      if (done) begin
        dc = k;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0; pattern = pat;
  endtask

  logic [63:0] bits;
  int nb, dc;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {x_out, x_valid, busy, done}, 4'b1000);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_xfer(4'b0110, 8'd1, 4'd0, -1, bits, nb, dc);
`ifdef SEQ_GEN_PARITY_EN
    chk("t1_bits", bits, 64'b01100);
`else
    chk("t1_bits", bits, 64'b0110);
`endif
    chk("t1_nbits", nb, L);
    chk("t1_done_cycle", dc, L + 1);

    run_xfer(4'b1010, 8'd3, 4'd2, -1, bits, nb, dc);
`ifdef SEQ_GEN_PARITY_EN
    chk("t2_bits", bits, 64'b101001010010100);
    chk("t2_done_cycle", dc, 20);
`else
    chk("t2_bits", bits, 64'b101010101010);
    chk("t2_done_cycle", dc, 17);
`endif
    chk("t2_nbits", nb, 3 * L);

    run_xfer(4'b0110, 8'd0, 4'd3, -1, bits, nb, dc);
    chk("t3_rep0_nbits", nb, L);
    chk("t3_rep0_done_cycle", dc, L + 1);

    run_xfer(4'b0110, 8'd2, 4'd0, -1, bits, nb, dc);
`ifdef SEQ_GEN_PARITY_EN
    chk("t3_b2b_bits", bits, 64'b0110001100);
`else
    chk("t3_b2b_bits", bits, 64'b01100110);
`endif
    chk("t3_b2b_done_cycle", dc, 2 * L + 1);

    run_xfer(4'b0111, 8'd1, 4'd0, -1, bits, nb, dc);
`ifdef SEQ_GEN_PARITY_EN
    chk("t6_parity_bits", bits, 64'b01111);
    chk("t6_parity_done_cycle", dc, 6);
`else
    chk("t6_bits", bits, 64'b0111);
    chk("t6_done_cycle", dc, 5);
`endif

    // abort during the 2nd bit of a 3-repetition transfer
    @(negedge clk);
    pattern = 4'b1011; repeat_cnt = 8'd3; gap = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle", {x_out, x_valid, busy, done}, 4'b1000);
    @(negedge clk);
    chk("abort_no_done", {busy, done}, 2'b00);
    run_xfer(4'b1011, 8'd1, 4'd0, -1, bits, nb, dc);
`ifdef SEQ_GEN_PARITY_EN
    chk("post_abort_bits", bits, 64'b10111);
`else
    chk("post_abort_bits", bits, 64'b1011);
`endif
    chk("post_abort_done_cycle", dc, L + 1);

    // start pulsed mid-SEND, then during DONE
    run_xfer(4'b1100, 8'd2, 4'd1, 2, bits, nb, dc);
`ifdef SEQ_GEN_PARITY_EN
    chk("start_in_send_bits", bits, 64'b1100011000);
`else
    chk("start_in_send_bits", bits, 64'b11001100);
`endif
    chk("start_in_send_done_cycle", dc, 2 * L + 2);
    run_xfer(4'b0101, 8'd1, 4'd0, L + 1, bits, nb, dc);
    chk("start_in_done_cycle", dc, L + 1);
    repeat (2) @(negedge clk);
    chk("start_in_done_ignored", {x_valid, busy}, 2'b00);

    // start and abort together in IDLE
    @(negedge clk);
    pattern = 4'b1111; repeat_cnt = 8'd1; gap = 4'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_c1", {x_valid, busy}, 2'b00);
    @(negedge clk);
    chk("start_abort_c2", {x_valid, busy, done}, 3'b000);

    // asynchronous reset mid-SEND
    @(negedge clk);
    pattern = 4'b1001; repeat_cnt = 8'd2; gap = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", x_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", {x_out, x_valid, busy, done}, 4'b1000);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {x_out, x_valid, busy, done}, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-pattern transmitter. It is the driving end of the single-bit serial stream consumed by the team's Mealy sequence detectors. It captures a PAT_W-bit pattern and sends it MSB-first, one bit per clock. The pattern can be repeated a programmable number of times, with programmable idle gaps between repetitions. Used as stimulus and loopback source for the 0110 detector and future detector variants.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2 to 32)
CNT_W, 8, width of repetition count
GAP_W, 4, width of inter-repetition gap count
IDLE_BIT, 1, level driven on x_out whenever no pattern bit is being sent

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request to transmit; sampled only in IDLE
pattern  input  PAT_W  pattern to send, MSB first; captured on an accepted start
repeat_cnt  input  CNT_W  number of repetitions; 0 is treated as 1; captured on an accepted start
gap  input  GAP_W  idle cycles between repetitions; captured on an accepted start
abort  input  1  synchronous cancel of the transfer in progress
x_out  output  1  serial data bit
x_valid  output  1  high when x_out carries a pattern (or parity) bit
busy  output  1  high from the cycle after an accepted start through the last bit
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset is asynchronous and active-low on rst_n; the clock is clk.
- Reset values: state=IDLE, x_out=IDLE_BIT, x_valid=0, busy=0, done=0, all internal counters and shadow registers 0. All outputs are registered.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 and abort=0 → capture pattern, repeat_cnt (0 mapped to 1) and gap into the shift register and counters; go to SEND.
  - The first bit, pattern[PAT_W-1], appears on x_out with x_valid=1 in the cycle after start is sampled. Latency is 1 cycle.
- SEND:
  - Each cycle drive the current MSB and shift left. A bit counter runs from 0 to PAT_W-1 (PAT_W with parity enabled).
  - After the last bit, decrement the repetition counter.
  - Repetitions remaining and gap>0 → GAP.
  - Repetitions remaining and gap=0 → reload the shift register from the shadow copy and continue in SEND. The next repetition's first bit follows back-to-back with no bubble.
  - No repetitions remaining → DONE.
- GAP: x_out=IDLE_BIT, x_valid=0, busy=1 for exactly gap cycles. Then reload the shift register and go to SEND.
- DONE: done=1, busy=0, x_valid=0, x_out=IDLE_BIT for one cycle, then IDLE. start is ignored in DONE.
- start while busy (SEND/GAP/DONE): ignored. Inputs captured at start are not re-sampled mid-transfer.
- abort:
  - In SEND or GAP: the next cycle is IDLE with x_out=IDLE_BIT, x_valid=0, busy=0. No done pulse is issued.
  - abort and start together in IDLE: abort wins and start is dropped.
- Total cycles from start to done for R repetitions and gap G: R*PAT_W + (R-1)*G + 1 (the final cycle is done). With parity enabled, substitute PAT_W+1 for PAT_W.
- Counters saturate nowhere. The repetition counter never wraps, because 0 is mapped to 1 at capture.
- rst_n asserted mid-transfer: outputs return to reset values immediately, asynchronously.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined: after every repetition's PAT_W bits, one extra bit is sent with x_valid=1. Its value is the even parity (XOR) of the captured pattern. Each repetition is therefore PAT_W+1 cycles long.
- Undefined: no parity bit is sent; each repetition is exactly PAT_W cycles.

Test Plan:
- pattern=4'b0110, repeat_cnt=1, gap=0, single-cycle start at cycle 0 → x_out/x_valid=0/1,1/1,1/1,0/1 in cycles 1-4; done=1 in cycle 5; busy high cycles 1-4. In loopback into the 0110 detector, z=1 during cycle 4.
- pattern=4'b1010, repeat_cnt=3, gap=2 → bits 1010, IDLE_BIT×2, 1010, IDLE_BIT×2, 1010; done exactly 17 cycles after start; x_valid low only during gaps.
- repeat_cnt=0, pattern=4'b0110 → behaves exactly as repeat_cnt=1; repeat_cnt=2 with gap=0 → 8 contiguous valid bits 01100110.
- abort asserted during 2nd bit of a 3-repetition transfer → next cycle state IDLE, x_out=IDLE_BIT, busy=0; no done pulse; new start 2 cycles later sends correctly from bit 0.
- start pulsed during SEND and during DONE → ignored, no change to stream; start+abort together in IDLE → nothing sent.
- With SEQ_GEN_PARITY_EN, pattern=4'b0111, repeat_cnt=1 → x_out 0,1,1,1,1 (parity 1); done in cycle 6. Also check rst_n low mid-SEND → x_valid=0 and x_out=IDLE_BIT immediately.
